// File: rtl/str_pkg.sv
// Shared types and constants for the string stream register.
// Contents: FSM state type, shift direction encodings, default word width.
package str_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned DEF_WORD_WIDTH = 8;

endpackage

// File: rtl/str_word_shifter.sv
// Combinational one-word shifter over the whole string buffer.
// Word 0 (head) sits in the MSBs, so a left shift moves data toward the MSBs.
// Ports:
//   i_data   - buffer contents
//   i_dir    - DIR_LEFT drops the head word, DIR_RIGHT inserts a zero head word
//   i_rot    - (STR_STREAM_ROTATE_EN only) wrap words around instead of zero fill
//   o_data_c - shifted buffer
// Optional feature macro: STR_STREAM_ROTATE_EN
module str_word_shifter
  import str_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned NUM_WORDS  = 16
) (
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] i_data,
  input  logic                            i_dir,
`ifdef STR_STREAM_ROTATE_EN
  input  logic                            i_rot,
`endif
  output logic [WORD_WIDTH*NUM_WORDS-1:0] o_data_c
);

  localparam int unsigned BUF_W = WORD_WIDTH * NUM_WORDS;

  // Shift by one word, zero fill (or wrap when rotating)
  always_comb begin
    o_data_c = '0;
    if (i_dir == DIR_RIGHT) begin
      o_data_c = {{WORD_WIDTH{1'b0}}, i_data[BUF_W-1:WORD_WIDTH]};
    end else begin
      o_data_c = {i_data[BUF_W-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
    end
`ifdef STR_STREAM_ROTATE_EN
    if (i_rot) begin
      if (i_dir == DIR_RIGHT) begin
        o_data_c = {i_data[WORD_WIDTH-1:0], i_data[BUF_W-1:WORD_WIDTH]};
      end else begin
        o_data_c = {i_data[BUF_W-WORD_WIDTH-1:0], i_data[BUF_W-1:BUF_W-WORD_WIDTH]};
      end
    end
`endif
  end

endmodule

// File: rtl/str_stream_register.sv
// String register with tail push, head pop, parallel load and a multi-word
// shift engine that moves one word per cycle.
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   str_load, str_in, len_in    - parallel load (len clamped to NUM_WORDS)
//   push_valid/push_word/push_ready - tail push handshake
//   pop_valid/pop_word/pop_ready    - head pop handshake
//   shift_start/shift_dir/shift_amt - multi-word shift request (IDLE only)
//   shift_rot                   - (STR_STREAM_ROTATE_EN only) rotate instead of shift
//   busy, str_out, len_out, full, empty - status and contents
// Optional feature macro: STR_STREAM_ROTATE_EN
module str_stream_register
  import str_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned NUM_WORDS  = 16,
  parameter int unsigned LEN_WIDTH  = $clog2(NUM_WORDS + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            str_load,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0] str_in,
  input  logic [LEN_WIDTH-1:0]            len_in,
  input  logic                            push_valid,
  input  logic [WORD_WIDTH-1:0]           push_word,
  output logic                            push_ready,
  output logic                            pop_valid,
  output logic [WORD_WIDTH-1:0]           pop_word,
  input  logic                            pop_ready,
  input  logic                            shift_start,
  input  logic                            shift_dir,
  input  logic [LEN_WIDTH-1:0]            shift_amt,
`ifdef STR_STREAM_ROTATE_EN
  input  logic                            shift_rot,
`endif
  output logic                            busy,
  output logic [WORD_WIDTH*NUM_WORDS-1:0] str_out,
  output logic [LEN_WIDTH-1:0]            len_out,
  output logic                            full,
  output logic                            empty
);

  localparam int unsigned         BUF_W   = WORD_WIDTH * NUM_WORDS;
  localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(NUM_WORDS);

  state_t               r_state;
  logic [BUF_W-1:0]     r_buf;
  logic [LEN_WIDTH-1:0] r_len;
  logic [LEN_WIDTH-1:0] r_cnt;
  logic                 r_dir;
  logic                 r_rot;

  logic                 w_busy;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_rot_start;
  logic                 w_sh_dir;
  logic [BUF_W-1:0]     w_sh_data;
  logic [LEN_WIDTH-1:0] w_len_clamp;
  logic [BUF_W-1:0]     w_load_buf;
  logic [BUF_W-1:0]     w_idle_buf;
  logic [LEN_WIDTH-1:0] w_idle_len;
  logic [LEN_WIDTH-1:0] w_shift_len;

  // Status and handshake outputs, all derived from registers only
  assign w_busy     = (r_state == SHIFT);
  assign w_full     = (r_len == LEN_MAX);
  assign w_empty    = (r_len == '0);
  assign busy       = w_busy;
  assign full       = w_full;
  assign empty      = w_empty;
  assign push_ready = !w_full && !w_busy;
  assign pop_valid  = !w_empty && !w_busy;
  assign pop_word   = r_buf[BUF_W-1 -: WORD_WIDTH];
  assign str_out    = r_buf;
  assign len_out    = r_len;

  assign w_pop  = pop_valid && pop_ready;
  assign w_push = push_valid && push_ready;

`ifdef STR_STREAM_ROTATE_EN
  assign w_rot_start = shift_rot;
`else
  assign w_rot_start = 1'b0;
`endif

  // The single shifter serves the pop path in IDLE and the shift engine in SHIFT
  assign w_sh_dir = w_busy ? r_dir : DIR_LEFT;

  str_word_shifter #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_shifter (
    .i_data   (r_buf),
    .i_dir    (w_sh_dir),
`ifdef STR_STREAM_ROTATE_EN
    .i_rot    (w_busy && r_rot),
`endif
    .o_data_c (w_sh_data)
  );

  // Parallel load: clamp length and zero words beyond it
  always_comb begin
    w_len_clamp = (len_in > LEN_MAX) ? LEN_MAX : len_in;
    w_load_buf  = str_in;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (LEN_WIDTH'(i) >= w_len_clamp) begin
        w_load_buf[WORD_WIDTH*(NUM_WORDS-1-i) +: WORD_WIDTH] = '0;
      end
    end
  end

  // Pop then push; the pop re-zeroes the tail so a prior rotate cannot leak data
  always_comb begin
    w_idle_buf = r_buf;
    w_idle_len = r_len;
    if (w_pop) begin
      w_idle_buf = w_sh_data;
      w_idle_len = r_len - LEN_WIDTH'(1);
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        if (LEN_WIDTH'(i) >= w_idle_len) begin
          w_idle_buf[WORD_WIDTH*(NUM_WORDS-1-i) +: WORD_WIDTH] = '0;
        end
      end
    end
    if (w_push) begin
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        if (LEN_WIDTH'(i) == w_idle_len) begin
          w_idle_buf[WORD_WIDTH*(NUM_WORDS-1-i) +: WORD_WIDTH] = push_word;
        end
      end
      w_idle_len = w_idle_len + LEN_WIDTH'(1);
    end
  end

  // Length after one shift step: saturating, unchanged when rotating
  always_comb begin
    w_shift_len = r_len;
    if (!r_rot) begin
      if (r_dir == DIR_LEFT) begin
        if (r_len != '0) w_shift_len = r_len - LEN_WIDTH'(1);
      end else begin
        if (r_len != LEN_MAX) w_shift_len = r_len + LEN_WIDTH'(1);
      end
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dir   <= DIR_LEFT;
      r_rot   <= 1'b0;
    end else if (str_load) begin
      // Load wins in both states and aborts any shift in progress
      r_state <= IDLE;
      r_buf   <= w_load_buf;
      r_len   <= w_len_clamp;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (shift_start && (shift_amt != '0)) begin
            r_state <= SHIFT;
            r_cnt   <= shift_amt;
            r_dir   <= shift_dir;
            r_rot   <= w_rot_start;
          end else begin
            r_buf <= w_idle_buf;
            r_len <= w_idle_len;
          end
        end
        SHIFT: begin
          r_buf <= w_sh_data;
          r_len <= w_shift_len;
          r_cnt <= r_cnt - LEN_WIDTH'(1);
          if (r_cnt == LEN_WIDTH'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_str_stream_register.sv
// Self-checking bench for str_stream_register (WORD_WIDTH=8, NUM_WORDS=16).
// The reference model holds the valid string as a queue of words.
module tb_str_stream_register;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int LW = 5;
  localparam int BW = W * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          str_load;
  logic [BW-1:0] str_in;
  logic [LW-1:0] len_in;
  logic          push_valid;
  logic [W-1:0]  push_word;
  logic          push_ready;
  logic          pop_valid;
  logic [W-1:0]  pop_word;
  logic          pop_ready;
  logic          shift_start;
  logic          shift_dir;
  logic [LW-1:0] shift_amt;
  logic          busy;
  logic [BW-1:0] str_out;
  logic [LW-1:0] len_out;
  logic          full;
  logic          empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_q[$];
  int           m_rem = 0;
  logic         m_dir = 1'b0;

  always #5 clk = ~clk;

  str_stream_register #(.WORD_WIDTH(W), .NUM_WORDS(N), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .str_load    (str_load),
    .str_in      (str_in),
    .len_in      (len_in),
    .push_valid  (push_valid),
    .push_word   (push_word),
    .push_ready  (push_ready),
    .pop_valid   (pop_valid),
    .pop_word    (pop_word),
    .pop_ready   (pop_ready),
    .shift_start (shift_start),
    .shift_dir   (shift_dir),
    .shift_amt   (shift_amt),
    .busy        (busy),
    .str_out     (str_out),
    .len_out     (len_out),
    .full        (full),
    .empty       (empty)
  );

  function automatic logic [BW-1:0] exp_str();
    logic [BW-1:0] s;
    s = '0;
    for (int i = 0; i < m_q.size(); i++) s[W*(N-1-i) +: W] = m_q[i];
    return s;
  endfunction

  function automatic logic [BW-1:0] rand_str();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Apply one clock of model behaviour for the currently driven inputs, then clock the DUT
  task automatic cycle();
    int  clamp;
    bit  do_pop;
    bit  do_push;
    if (!rst_n) begin
      m_q.delete();
      m_rem = 0;
    end else if (str_load) begin
      m_q.delete();
      clamp = (int'(len_in) > N) ? N : int'(len_in);
      for (int i = 0; i < clamp; i++) m_q.push_back(str_in[W*(N-1-i) +: W]);
      m_rem = 0;
    end else if (m_rem > 0) begin
      if (m_dir == 1'b0) begin
        if (m_q.size() > 0) m_q.delete(0);
      end else begin
        m_q.push_front('0);
        if (m_q.size() > N) m_q.delete(m_q.size() - 1);
      end
      m_rem--;
    end else if (shift_start && shift_amt != 0) begin
      m_rem = int'(shift_amt);
      m_dir = shift_dir;
    end else begin
      do_pop  = pop_ready && (m_q.size() > 0);
      do_push = push_valid && (m_q.size() < N);
      if (do_pop) m_q.delete(0);
      if (do_push) m_q.push_back(push_word);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    str_load    = 1'b0;
    str_in      = '0;
    len_in      = '0;
    push_valid  = 1'b0;
    push_word   = '0;
    pop_ready   = 1'b0;
    shift_start = 1'b0;
    shift_dir   = 1'b0;
    shift_amt   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_checks++;
    if ({busy, pop_valid, push_ready, empty, full} !== 5'b00110) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=00110", {busy, pop_valid, push_ready, empty, full});
    end
    n_checks++;
    if (len_out !== '0 || str_out !== '0) begin
      n_fail++;
      $display("FAIL reset_state len=%0d str=%h exp len=0 str=0", len_out, str_out);
    end
  endtask

  task automatic test_push();
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1;
      push_word  = W'(8'h41 + i);
      cycle();
    end
    push_valid = 1'b0;
    n_checks++;
    if (len_out !== LW'(3) || str_out[127:104] !== 24'h414243 || str_out[103:0] !== '0) begin
      n_fail++;
      $display("FAIL push3 len=%0d str=%h exp len=3 str=414243 then zeros", len_out, str_out);
    end
    n_checks++;
    if (pop_word !== 8'h41 || pop_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL push3_head pop_word=%h pop_valid=%b exp 41/1", pop_word, pop_valid);
    end
  endtask

  task automatic test_pop_push();
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_word  = 8'h44;
    cycle();
    pop_ready  = 1'b0;
    push_valid = 1'b0;
    n_checks++;
    if (pop_word !== 8'h42 || len_out !== LW'(3) || str_out[127:104] !== 24'h424344
        || str_out[103:0] !== '0) begin
      n_fail++;
      $display("FAIL pop_push head=%h len=%0d str=%h exp 42/3/424344", pop_word, len_out, str_out);
    end
  endtask

  task automatic test_full();
    while (m_q.size() < N) begin
      push_valid = 1'b1;
      push_word  = W'($urandom());
      cycle();
    end
    push_valid = 1'b0;
    n_checks++;
    if (full !== 1'b1 || push_ready !== 1'b0 || len_out !== LW'(16) || str_out !== exp_str()) begin
      n_fail++;
      $display("FAIL fill full=%b push_ready=%b len=%0d str=%h exp 1/0/16 str=%h",
               full, push_ready, len_out, str_out, exp_str());
    end
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_word  = 8'hEE;
    cycle();
    pop_ready  = 1'b0;
    push_valid = 1'b0;
    n_checks++;
    if (len_out !== LW'(15) || str_out !== exp_str() || str_out[7:0] !== 8'h00) begin
      n_fail++;
      $display("FAIL full_pop_push len=%0d str=%h exp len=15 str=%h", len_out, str_out, exp_str());
    end
  endtask

  task automatic test_shift_left();
    int cnt;
    str_load = 1'b1;
    str_in   = '1;
    len_in   = LW'(4);
    cycle();
    str_load = 1'b0;
    n_checks++;
    if (len_out !== LW'(4) || str_out !== {32'hFFFF_FFFF, 96'h0}) begin
      n_fail++;
      $display("FAIL load4 len=%0d str=%h exp len=4 str=ffffffff then zeros", len_out, str_out);
    end
    shift_start = 1'b1;
    shift_dir   = 1'b0;
    shift_amt   = LW'(2);
    cycle();
    shift_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10 && busy === 1'b1; k++) begin
      cnt++;
      cycle();
    end
    n_checks++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL shl_latency busy_cycles=%0d exp=2", cnt);
    end
    n_checks++;
    if (len_out !== LW'(2) || str_out !== {16'hFFFF, 112'h0}) begin
      n_fail++;
      $display("FAIL shl_result len=%0d str=%h exp len=2 str=ffff then zeros", len_out, str_out);
    end
  endtask

  task automatic test_shift_right_abort();
    int cnt;
    str_load = 1'b1;
    str_in   = rand_str();
    len_in   = LW'(15);
    cycle();
    str_load    = 1'b0;
    shift_start = 1'b1;
    shift_dir   = 1'b1;
    shift_amt   = LW'(3);
    cycle();
    shift_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10 && busy === 1'b1; k++) begin
      cnt++;
      cycle();
    end
    n_checks++;
    if (cnt != 3 || len_out !== LW'(16) || str_out[127:104] !== 24'h0 || str_out !== exp_str()) begin
      n_fail++;
      $display("FAIL shr_sat cycles=%0d len=%0d str=%h exp 3/16 str=%h", cnt, len_out, str_out, exp_str());
    end
    shift_start = 1'b1;
    shift_dir   = 1'b1;
    shift_amt   = LW'(5);
    cycle();
    shift_start = 1'b0;
    cycle();
    str_load = 1'b1;
    str_in   = rand_str();
    len_in   = LW'(7);
    cycle();
    str_load = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || len_out !== LW'(7) || str_out !== exp_str()) begin
      n_fail++;
      $display("FAIL shift_abort busy=%b len=%0d str=%h exp 0/7 str=%h", busy, len_out, str_out, exp_str());
    end
  endtask

  task automatic test_reset_mid_shift();
    shift_start = 1'b1;
    shift_dir   = 1'b0;
    shift_amt   = LW'(4);
    cycle();
    shift_start = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    n_checks++;
    if (len_out !== '0 || busy !== 1'b0 || str_out !== '0 || push_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_shift len=%0d busy=%b str=%h push_ready=%b exp 0/0/0/1",
               len_out, busy, str_out, push_ready);
    end
  endtask

  task automatic test_shift_zero();
    str_load = 1'b1;
    str_in   = rand_str();
    len_in   = LW'(5);
    cycle();
    str_load    = 1'b0;
    shift_start = 1'b1;
    shift_amt   = '0;
    cycle();
    shift_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || len_out !== LW'(5) || str_out !== exp_str()) begin
      n_fail++;
      $display("FAIL shift_zero busy=%b len=%0d exp busy=0 len=5", busy, len_out);
    end
    cycle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL shift_zero_late busy=%b exp=0", busy);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] head;
    for (int it = 0; it < 600; it++) begin
      str_load    = ($urandom_range(0, 99) < 4);
      str_in      = rand_str();
      len_in      = LW'($urandom_range(0, 31));
      shift_start = ($urandom_range(0, 99) < 10);
      shift_dir   = 1'($urandom());
      shift_amt   = LW'($urandom_range(0, 7));
      push_valid  = ($urandom_range(0, 99) < 55);
      push_word   = W'($urandom());
      pop_ready   = ($urandom_range(0, 99) < 45);
      cycle();
      head = (m_q.size() > 0) ? m_q[0] : '0;
      n_checks++;
      if (len_out !== LW'(m_q.size()) || str_out !== exp_str() || pop_word !== head) begin
        n_fail++;
        $display("FAIL rand_data it=%0d len=%0d str=%h exp len=%0d str=%h",
                 it, len_out, str_out, m_q.size(), exp_str());
      end
      n_checks++;
      if (busy !== (m_rem > 0) || pop_valid !== (m_q.size() > 0 && m_rem == 0)
          || push_ready !== (m_q.size() < N && m_rem == 0)
          || full !== (m_q.size() == N) || empty !== (m_q.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_flags it=%0d busy=%b pv=%b pr=%b full=%b empty=%b len_model=%0d rem=%0d",
                 it, busy, pop_valid, push_ready, full, empty, m_q.size(), m_rem);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_push();
    test_pop_push();
    test_full();
    test_shift_left();
    test_shift_right_abort();
    test_reset_mid_shift();
    test_shift_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/str_stream_register.md
Name: str_stream_register

Overview:
- Parametrised successor to the fixed 128-bit string register. Holds NUM_WORDS words of WORD_WIDTH bits and tracks the valid string length.
- Adds a valid/ready push port at the tail and a valid/ready pop port at the head.
- Adds a multi-word shift engine that moves one word per cycle under a small FSM.
- Sits between the byte-stream front end and the string-compare datapath, which reads str_out in parallel.

Parameters:
- WORD_WIDTH, 8: bits per word.
- NUM_WORDS, 16: string capacity in words. Minimum 2.
- LEN_WIDTH, $clog2(NUM_WORDS+1): width of the length and shift-amount fields.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; active-low and synchronous.
- str_load  in  1  parallel load of str_in and len_in.
- str_in  in  WORD_WIDTH*NUM_WORDS  string to load; word 0 (head) is in the MSBs.
- len_in  in  LEN_WIDTH  length loaded with str_in; values above NUM_WORDS are clamped to NUM_WORDS.
- push_valid  in  1  a tail word is offered.
- push_word  in  WORD_WIDTH  the tail word.
- push_ready  out  1  = !full && !busy.
- pop_valid  out  1  = !empty && !busy.
- pop_word  out  WORD_WIDTH  head word (word 0).
- pop_ready  in  1  consumer takes the head word.
- shift_start  in  1  start a multi-word shift; sampled only in IDLE.
- shift_dir  in  1  0 = left (toward head, drops head words), 1 = right (inserts zero words at head).
- shift_amt  in  LEN_WIDTH  number of words to shift.
- busy  out  1  high while in SHIFT.
- str_out  out  WORD_WIDTH*NUM_WORDS  full buffer contents.
- len_out  out  LEN_WIDTH  current valid length.
- full  out  1  len == NUM_WORDS.
- empty  out  1  len == 0.

Behaviour:
- Reset (rst_n low at clk edge): buffer = 0, len = 0, state = IDLE, shift counter = 0. Resulting outputs: busy = 0, pop_valid = 0, push_ready = 1, empty = 1, full = 0.
- Reset mid-shift aborts the shift immediately.
- Word i occupies bits [W*(NUM_WORDS-i)-1 : W*(NUM_WORDS-i-1)]. pop_word is word 0.
- Words at indices >= len are kept at zero at all times.
- All outputs are driven combinationally from registers; there is no input-to-output combinational path.

IDLE, evaluated in priority order:
1. str_load: buffer <= str_in, with words at indices >= clamped len forced to zero; len <= clamped len_in. push, pop and shift_start are ignored that cycle.
2. shift_start with shift_amt > 0: go to SHIFT with counter = shift_amt. Push and pop are ignored that cycle. shift_amt == 0 is a no-op and the FSM stays in IDLE.
3. Pop (pop_valid && pop_ready) and/or push (push_valid && push_ready):
   - Pop only: buffer shifts left one word, zero fill at the tail; len - 1.
   - Push only: word[len] <= push_word; len + 1.
   - Both in the same cycle: pop first, then push_word is written at index len-1; len unchanged.
   - len == 1 with both: push_word becomes the new head.
   - full blocks push even when a pop happens in the same cycle. push_ready does not look ahead.

SHIFT (busy = 1): one word per cycle; the counter decrements each cycle.
- Left shift: len <= max(len-1, 0). Once len hits 0 the buffer stays zero.
- Right shift: a zero word is inserted at the head and the tail word is discarded; len <= min(len+1, NUM_WORDS).
- On the cycle the counter reaches 1, return to IDLE. Latency is exactly shift_amt cycles.
- str_load during SHIFT aborts the shift and loads; the FSM is in IDLE the next cycle.
- push_valid, pop_ready and shift_start are ignored during SHIFT.

Optional Feature:
- Macro: STR_STREAM_ROTATE_EN.
- Defined: adds input port shift_rot (1 bit), sampled with shift_start.
  - shift_rot = 1: words wrap around the full NUM_WORDS ring, len is unchanged, and the zero-above-len invariant is suspended until the next str_load, pop or reset.
  - shift_rot = 0: behaviour is identical to the undefined case.
- Undefined: the port is absent and only shift behaviour is implemented.

Decomposition:
- Package str_pkg holds:
  - state typedef {IDLE, SHIFT};
  - constants DIR_LEFT = 0 and DIR_RIGHT = 1;
  - a default WORD_WIDTH of 8.
- Sub-module str_word_shifter: combinational one-word left/right (and, under the macro, rotate) shifter, parametrised by WORD_WIDTH and NUM_WORDS. It is reused by the pop path and the SHIFT state.

Test Plan (WORD_WIDTH=8, NUM_WORDS=16):
- Push 0x41, 0x42, 0x43 on consecutive cycles -> len_out = 3, str_out[127:104] = 0x414243, rest zero, pop_word = 0x41.
- len = 3 (0x41,0x42,0x43); pop and push 0x44 in the same cycle -> pop_word becomes 0x42, words are 0x42,0x43,0x44, len stays 3.
- Fill to 16 words -> full = 1, push_ready = 0. A push attempt with concurrent pop -> pop only, len = 15.
- str_load with len_in = 4 and all-0xFF str_in, then shift left by 2 -> busy for exactly 2 cycles, len = 2, words = 0xFF,0xFF, rest zero.
- Shift right by 3 from len = 15 -> len saturates at 16, head three words = 0x00. str_load asserted on cycle 2 of a second shift -> the shift aborts, busy = 0 next cycle, loaded data is visible.
- rst_n low during SHIFT -> next cycle len = 0, busy = 0, str_out = 0, push_ready = 1. Also check shift_amt = 0 -> busy never asserts.
